// File: rtl/pass_exec.sv
// Pass executor: walks a memory window forward (f0/f1) or backward (b), accumulating read data.
// Optional build macro ACC_SAT_EN makes the accumulator saturate instead of wrapping.
module pass_exec #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            f0_pass_i,
    input  logic            f1_pass_i,
    input  logic            b_pass_i,
    input  logic [AW-1:0]   len_i,
    input  logic [2*DW-1:0] thr_i,
    input  logic [DW-1:0]   data_i,
    input  logic            data_vld_i,
    output logic            rd_o,
    output logic [AW-1:0]   addr_o,
    output logic [2*DW-1:0] acc_o,
    output logic            busy_o,
    output logic            f0_end_o,
    output logic            f1_end_o,
    output logic            b_end_o,
    output logic            end_check_o,
    output logic            err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        P_F0 = 2'd0,
        P_F1 = 2'd1,
        P_B  = 2'd2
    } pass_t;

    // Accumulator add; carry-out either saturates or is discarded depending on build
    function automatic logic [2*DW-1:0] acc_add(input logic [2*DW-1:0] acc,
                                                input logic [DW-1:0]   data);
        logic [2*DW:0] sum;
        sum = {1'b0, acc} + {{(DW+1){1'b0}}, data};
`ifdef ACC_SAT_EN
        if (sum[2*DW]) begin
            acc_add = {(2*DW){1'b1}};
        end else begin
            acc_add = sum[2*DW-1:0];
        end
`else
        acc_add = sum[2*DW-1:0];
`endif
    endfunction

    state_t          state_q, state_d;
    pass_t           pass_q, pass_d;
    logic [AW-1:0]   len_q, len_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2*DW-1:0] acc_q, acc_d;
    logic            rd_q, rd_d;
    logic            busy_q, busy_d;
    logic            f0_end_q, f0_end_d;
    logic            f1_end_q, f1_end_d;
    logic            b_end_q, b_end_d;
    logic            chk_q, chk_d;
    logic            err_q, err_d;

    logic [1:0]      req_cnt_s;
    logic            lvl_s;

    assign req_cnt_s = {1'b0, f0_pass_i} + {1'b0, f1_pass_i} + {1'b0, b_pass_i};

    // Level of the request input belonging to the pass in progress
    always_comb begin
        lvl_s = 1'b0;
        case (pass_q)
            P_F0:    lvl_s = f0_pass_i;
            P_F1:    lvl_s = f1_pass_i;
            P_B:     lvl_s = b_pass_i;
            default: lvl_s = 1'b0;
        endcase
    end

    // Next-state and datapath; pulse flops are recomputed every cycle so they never stretch
    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        acc_d    = acc_q;
        err_d    = err_q;
        f0_end_d = 1'b0;
        f1_end_d = 1'b0;
        b_end_d  = 1'b0;
        chk_d    = 1'b0;
        if (en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (req_cnt_s == 2'd1) begin
                        if (f0_pass_i) begin
                            pass_d = P_F0;
                        end else if (f1_pass_i) begin
                            pass_d = P_F1;
                        end else begin
                            pass_d = P_B;
                        end
                        len_d  = len_i;
                        cnt_d  = {AW{1'b0}};
                        acc_d  = {(2*DW){1'b0}};
                        addr_d = b_pass_i ? (len_i - {{(AW-1){1'b0}}, 1'b1}) : {AW{1'b0}};
                        state_d = (len_i == {AW{1'b0}}) ? S_DONE : S_RUN;
                    end else if (req_cnt_s > 2'd1) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    // Abort takes priority over a beat arriving in the same cycle
                    if (!lvl_s) begin
                        state_d = S_IDLE;
                    end else if (data_vld_i && rd_q) begin
                        acc_d = acc_add(acc_q, data_i);
                        if (cnt_q == (len_q - {{(AW-1){1'b0}}, 1'b1})) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d  = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                            addr_d = (pass_q == P_B) ? (addr_q - {{(AW-1){1'b0}}, 1'b1})
                                                     : (addr_q + {{(AW-1){1'b0}}, 1'b1});
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    state_d = S_HOLD;
                    case (pass_q)
                        P_F0: begin
                            f0_end_d = 1'b1;
                            chk_d    = (acc_q >= thr_i);
                        end
                        P_F1:    f1_end_d = 1'b1;
                        P_B:     b_end_d  = 1'b1;
                        default: f0_end_d = 1'b0;
                    endcase
                end
                S_HOLD: begin
                    if (!lvl_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
        rd_d   = (state_d == S_RUN);
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            pass_q   <= P_F0;
            len_q    <= {AW{1'b0}};
            cnt_q    <= {AW{1'b0}};
            addr_q   <= {AW{1'b0}};
            acc_q    <= {(2*DW){1'b0}};
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
            f0_end_q <= 1'b0;
            f1_end_q <= 1'b0;
            b_end_q  <= 1'b0;
            chk_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            acc_q    <= acc_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            f0_end_q <= f0_end_d;
            f1_end_q <= f1_end_d;
            b_end_q  <= b_end_d;
            chk_q    <= chk_d;
            err_q    <= err_d;
        end
    end

    assign rd_o        = rd_q;
    assign addr_o      = addr_q;
    assign acc_o       = acc_q;
    assign busy_o      = busy_q;
    assign f0_end_o    = f0_end_q;
    assign f1_end_o    = f1_end_q;
    assign b_end_o     = b_end_q;
    assign end_check_o = chk_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_pass_exec.sv
// Directed self-checking bench for pass_exec (AW widened to 9 so one pass can overflow the accumulator).
module tb_pass_exec;
    localparam int AW = 9;
    localparam int DW = 8;

    logic            clk_i = 1'b0;
    logic            rst_i, en_i, f0_pass_i, f1_pass_i, b_pass_i, data_vld_i;
    logic [AW-1:0]   len_i;
    logic [2*DW-1:0] thr_i;
    logic [DW-1:0]   data_i;
    logic            rd_o, busy_o, f0_end_o, f1_end_o, b_end_o, end_check_o, err_o;
    logic [AW-1:0]   addr_o;
    logic [2*DW-1:0] acc_o;

    int total = 0;
    int bad = 0;

    pass_exec #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
        .f0_pass_i(f0_pass_i), .f1_pass_i(f1_pass_i), .b_pass_i(b_pass_i),
        .len_i(len_i), .thr_i(thr_i), .data_i(data_i), .data_vld_i(data_vld_i),
        .rd_o(rd_o), .addr_o(addr_o), .acc_o(acc_o), .busy_o(busy_o),
        .f0_end_o(f0_end_o), .f1_end_o(f1_end_o), .b_end_o(b_end_o),
        .end_check_o(end_check_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b0;
        tick(); tick();
        total++; if (rd_o !== 1'b0) begin bad++; $display("FAIL reset_rd: got %0b want 0", rd_o); end
        total++; if (addr_o !== 9'd0) begin bad++; $display("FAIL reset_addr: got %0h want 0", addr_o); end
        total++; if (acc_o !== 16'd0) begin bad++; $display("FAIL reset_acc: got %0h want 0", acc_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
        total++; if ({f0_end_o, f1_end_o, b_end_o, end_check_o, err_o} !== 5'b00000) begin
            bad++; $display("FAIL reset_flags: got %05b want 00000", {f0_end_o, f1_end_o, b_end_o, end_check_o, err_o}); end
        rst_i = 1'b0; en_i = 1'b1;
    endtask

    task automatic test_forward();
        f0_pass_i = 1'b1; len_i = 9'd4; thr_i = 16'd10; data_vld_i = 1'b0;
        tick();
        len_i = 9'd1;
        total++; if (rd_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL fwd_start: rd=%0b busy=%0b want 1 1", rd_o, busy_o); end
        for (int i = 0; i < 4; i++) begin
            total++; if (addr_o !== AW'(i)) begin bad++; $display("FAIL fwd_addr: got %0d want %0d", addr_o, i); end
            data_vld_i = 1'b0; tick();
            total++; if (addr_o !== AW'(i)) begin bad++; $display("FAIL fwd_addr_hold: got %0d want %0d", addr_o, i); end
            data_vld_i = 1'b1; data_i = DW'(i + 1); tick();
        end
        data_vld_i = 1'b0;
        total++; if (acc_o !== 16'd10) begin bad++; $display("FAIL fwd_acc: got %0d want 10", acc_o); end
        total++; if (rd_o !== 1'b0 || f0_end_o !== 1'b0) begin bad++; $display("FAIL fwd_done: rd=%0b f0_end=%0b want 0 0", rd_o, f0_end_o); end
        tick();
        total++; if (f0_end_o !== 1'b1 || end_check_o !== 1'b1) begin bad++; $display("FAIL fwd_pulse: f0_end=%0b chk=%0b want 1 1", f0_end_o, end_check_o); end
        tick();
        total++; if (f0_end_o !== 1'b0 || end_check_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++; $display("FAIL fwd_hold: f0_end=%0b chk=%0b busy=%0b want 0 0 1", f0_end_o, end_check_o, busy_o); end
        f0_pass_i = 1'b0; tick();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL fwd_idle: busy=%0b want 0", busy_o); end
    endtask

    task automatic test_backward();
        b_pass_i = 1'b1; len_i = 9'd3; thr_i = 16'd0; data_vld_i = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++; if (addr_o !== AW'(2 - i)) begin bad++; $display("FAIL bwd_addr: got %0d want %0d", addr_o, 2 - i); end
            data_vld_i = 1'b1; data_i = DW'(5 + i); tick();
        end
        data_vld_i = 1'b0;
        total++; if (acc_o !== 16'd18) begin bad++; $display("FAIL bwd_acc: got %0d want 18", acc_o); end
        tick();
        total++; if ({b_end_o, f0_end_o, f1_end_o, end_check_o} !== 4'b1000) begin
            bad++; $display("FAIL bwd_pulse: got %04b want 1000", {b_end_o, f0_end_o, f1_end_o, end_check_o}); end
        tick();
        total++; if (b_end_o !== 1'b0) begin bad++; $display("FAIL bwd_once: got %0b want 0", b_end_o); end
        b_pass_i = 1'b0; tick();
    endtask

    task automatic test_conflict();
        f0_pass_i = 1'b1; f1_pass_i = 1'b1; len_i = 9'd2;
        tick();
        total++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL conflict: err=%0b busy=%0b want 1 0", err_o, busy_o); end
        f0_pass_i = 1'b0; f1_pass_i = 1'b0; tick();
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0b want 1", err_o); end
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_reset: got %0b want 0", err_o); end
    endtask

    task automatic test_len_zero();
        f1_pass_i = 1'b1; len_i = 9'd0;
        tick();
        total++; if (f1_end_o !== 1'b0 || busy_o !== 1'b1 || rd_o !== 1'b0) begin
            bad++; $display("FAIL len0_done: f1_end=%0b busy=%0b rd=%0b want 0 1 0", f1_end_o, busy_o, rd_o); end
        tick();
        total++; if (f1_end_o !== 1'b1) begin bad++; $display("FAIL len0_pulse: got %0b want 1", f1_end_o); end
        tick();
        total++; if (f1_end_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL len0_hold: f1_end=%0b busy=%0b want 0 1", f1_end_o, busy_o); end
        f1_pass_i = 1'b0; tick();
    endtask

    task automatic test_abort_stall();
        f0_pass_i = 1'b1; len_i = 9'd8; thr_i = 16'd0; data_vld_i = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            data_vld_i = 1'b1; data_i = 8'd1; tick();
        end
        total++; if (addr_o !== 9'd3 || acc_o !== 16'd3) begin bad++; $display("FAIL abort_pre: addr=%0d acc=%0d want 3 3", addr_o, acc_o); end
        en_i = 1'b0; data_i = 8'd7;
        for (int i = 0; i < 5; i++) tick();
        total++; if (addr_o !== 9'd3 || acc_o !== 16'd3 || rd_o !== 1'b1) begin
            bad++; $display("FAIL stall_frozen: addr=%0d acc=%0d rd=%0b want 3 3 1", addr_o, acc_o, rd_o); end
        en_i = 1'b1; data_vld_i = 1'b0; f0_pass_i = 1'b0;
        tick();
        total++; if (busy_o !== 1'b0 || rd_o !== 1'b0 || acc_o !== 16'd3 || f0_end_o !== 1'b0) begin
            bad++; $display("FAIL abort_idle: busy=%0b rd=%0b acc=%0d f0_end=%0b want 0 0 3 0", busy_o, rd_o, acc_o, f0_end_o); end
        tick();
        total++; if (f0_end_o !== 1'b0) begin bad++; $display("FAIL abort_nopulse: got %0b want 0", f0_end_o); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_acc;
`ifdef ACC_SAT_EN
        exp_acc = 16'hFFFF;
`else
        exp_acc = 16'h2AD4;
`endif
        f0_pass_i = 1'b1; len_i = 9'd300; thr_i = 16'd0; data_vld_i = 1'b0;
        tick();
        data_vld_i = 1'b1; data_i = 8'hFF;
        for (int i = 0; i < 300; i++) tick();
        data_vld_i = 1'b0;
        total++; if (acc_o !== exp_acc) begin bad++; $display("FAIL ovf_acc: got %0h want %0h", acc_o, exp_acc); end
        total++; if (addr_o !== 9'd299) begin bad++; $display("FAIL ovf_addr: got %0d want 299", addr_o); end
        tick();
        total++; if (f0_end_o !== 1'b1 || end_check_o !== 1'b1) begin bad++; $display("FAIL ovf_pulse: f0_end=%0b chk=%0b want 1 1", f0_end_o, end_check_o); end
        f0_pass_i = 1'b0; tick(); tick();
    endtask

    task automatic test_reset_in_done();
        f1_pass_i = 1'b1; len_i = 9'd1; data_vld_i = 1'b0;
        tick();
        data_vld_i = 1'b1; data_i = 8'd9; tick();
        data_vld_i = 1'b0; rst_i = 1'b1; tick();
        total++; if (f1_end_o !== 1'b0 || busy_o !== 1'b0 || acc_o !== 16'd0) begin
            bad++; $display("FAIL rst_done: f1_end=%0b busy=%0b acc=%0d want 0 0 0", f1_end_o, busy_o, acc_o); end
        rst_i = 1'b0; tick();
        total++; if (f1_end_o !== 1'b0) begin bad++; $display("FAIL rst_nopulse: got %0b want 0", f1_end_o); end
        f1_pass_i = 1'b0; tick();
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b0; f0_pass_i = 1'b0; f1_pass_i = 1'b0; b_pass_i = 1'b0;
        len_i = 9'd0; thr_i = 16'd0; data_i = 8'd0; data_vld_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_forward();
        test_backward();
        test_conflict();
        test_len_zero();
        test_abort_stall();
        test_overflow();
        test_reset_in_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
